// File: rtl/ysyx_24100012_ifu_bus.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_ifu_bus
//
// Multi-cycle instruction fetch unit for a bus-attached instruction memory.
// The unit owns the PC, issues one fetch at a time over a valid/ready request
// channel, captures the returned word and holds it for decode behind a second
// valid/ready handshake. Execute may redirect the PC at any time, and an
// in-flight fetch whose address has been superseded is discarded.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   redirect_valid/_pc        taken branch / jump target from execute
//   imem_req_valid/_ready     fetch request handshake
//   imem_req_addr             fetch address (the PC register)
//   imem_resp_valid/_data     fetch response, one per accepted request
//   out_valid/_ready          instruction handshake towards decode
//   out_inst, out_pc          held instruction and its PC
//   out_pc_next               out_pc + WORD_SIZE (link value)
//   fetch_cnt                 number of instructions delivered to decode
// ----------------------------------------------------------------------------
module ysyx_24100012_ifu_bus #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]  ORIGIN_ADDR = 32'h8000_0000,
  parameter int unsigned            WORD_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc_next,
  output logic [31:0]           fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(WORD_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  kill_q, kill_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [31:0]           fetch_cnt_q, fetch_cnt_d;

  // Output decode straight from the state; a redirect masks out_valid so a
  // wrong-path instruction is never handed to decode.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_HOLD) && !redirect_valid;
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_pc_next    = pc_q + PC_STEP;
  assign fetch_cnt      = fetch_cnt_q;

  // Next-state, PC, kill flag, instruction buffer and delivery counter.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    inst_d      = inst_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      S_REQ: begin
        // The address may move freely until the memory takes the request.
        if (redirect_valid) begin
          pc_d = redirect_pc;
        end else begin
          pc_d = pc_q;
        end
        if (imem_req_ready) begin
          state_d = S_WAIT;
          // Accepted with the old address while a redirect arrives: the
          // coming response belongs to the wrong path.
          kill_d  = redirect_valid;
        end else begin
          state_d = S_REQ;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d   = redirect_pc;
          kill_d = 1'b1;
        end else begin
          pc_d   = pc_q;
        end
        if (imem_resp_valid) begin
          if (kill_q || redirect_valid) begin
            // Stale response: drop it and refetch from the new PC.
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d  = imem_resp_data;
            state_d = S_HOLD;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d        = pc_q + PC_STEP;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end

      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= ORIGIN_ADDR;
      kill_q      <= 1'b0;
      inst_q      <= '0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      inst_q      <= inst_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24100012_ifu_bus.sv
// ----------------------------------------------------------------------------
// Testbench for ysyx_24100012_ifu_bus. A directed vector table covers reset,
// sequential fetch and decode backpressure; hand-written sequences cover
// in-flight kill, redirect coinciding with a response, redirect while the
// request is stalled, redirect in HOLD and reset in the middle of operation.
// Inputs change 1 time unit after the rising edge, outputs are checked 2
// time units after the edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24100012_ifu_bus;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_next;
  logic [31:0] fetch_cnt;

  int errors = 0;
  int checks = 0;

  ysyx_24100012_ifu_bus dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_pc_next     (out_pc_next),
    .fetch_cnt       (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_v;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        rsv;
    logic [31:0] rsd;
    logic        ordy;
    logic        do_chk;
    logic        e_rqv;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 20;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic r, input logic rv, input logic [31:0] rpc, input logic rdy,
    input logic rsv, input logic [31:0] rsd, input logic ordy, input logic c,
    input logic e_rqv, input logic [31:0] e_addr, input logic e_ov,
    input logic [31:0] e_pc, input logic [31:0] e_inst, input logic [31:0] e_cnt);
    vec_t v;
    v.rst_v = r;  v.rv = rv;  v.rpc = rpc;  v.rdy = rdy;  v.rsv = rsv;
    v.rsd = rsd;  v.ordy = ordy;  v.do_chk = c;  v.e_rqv = e_rqv;
    v.e_addr = e_addr;  v.e_ov = e_ov;  v.e_pc = e_pc;  v.e_inst = e_inst;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_rqv, input logic [31:0] e_addr,
                         input logic e_ov, input logic [31:0] e_pc,
                         input logic [31:0] e_inst, input logic [31:0] e_cnt);
    chk($sformatf("%s.req_valid", tag), 32'(imem_req_valid), 32'(e_rqv));
    chk($sformatf("%s.req_addr", tag), imem_req_addr, e_addr);
    chk($sformatf("%s.out_valid", tag), 32'(out_valid), 32'(e_ov));
    chk($sformatf("%s.out_pc", tag), out_pc, e_pc);
    chk($sformatf("%s.out_pc_next", tag), out_pc_next, e_pc + 32'd4);
    chk($sformatf("%s.out_inst", tag), out_inst, e_inst);
    chk($sformatf("%s.fetch_cnt", tag), fetch_cnt, e_cnt);
  endtask

  task automatic set_in(input logic r, input logic rv, input logic [31:0] rpc,
                        input logic rdy, input logic rsv, input logic [31:0] rsd,
                        input logic ordy);
    rst             = r;
    redirect_valid  = rv;
    redirect_pc     = rpc;
    imem_req_ready  = rdy;
    imem_resp_valid = rsv;
    imem_resp_data  = rsd;
    out_ready       = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
  endtask

  initial begin
    logic [31:0] p;

    // Reset, three sequential fetches (memory returns addr ^ 0x13 one cycle
    // after acceptance), then a fourth fetch held for 5 cycles by decode.
    tbl[0]  = mk(1'b0,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b0, 1'b0,32'd0,1'b0,32'd0,32'd0,32'd0);
    tbl[1]  = mk(1'b0,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h80000000,1'b0,32'h80000000,32'd0,32'd0);
    tbl[2]  = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h80000000,1'b0,32'h80000000,32'd0,32'd0);
    tbl[3]  = mk(1'b1,1'b0,32'd0,1'b1,1'b1,32'h80000013,1'b1, 1'b1, 1'b0,32'h80000000,1'b0,32'h80000000,32'd0,32'd0);
    tbl[4]  = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b0,32'h80000000,1'b1,32'h80000000,32'h80000013,32'd0);
    tbl[5]  = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h80000004,1'b0,32'h80000004,32'h80000013,32'd1);
    tbl[6]  = mk(1'b1,1'b0,32'd0,1'b1,1'b1,32'h80000017,1'b1, 1'b1, 1'b0,32'h80000004,1'b0,32'h80000004,32'h80000013,32'd1);
    tbl[7]  = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b0,32'h80000004,1'b1,32'h80000004,32'h80000017,32'd1);
    tbl[8]  = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h80000008,1'b0,32'h80000008,32'h80000017,32'd2);
    tbl[9]  = mk(1'b1,1'b0,32'd0,1'b1,1'b1,32'h8000001B,1'b1, 1'b1, 1'b0,32'h80000008,1'b0,32'h80000008,32'h80000017,32'd2);
    tbl[10] = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b0,32'h80000008,1'b1,32'h80000008,32'h8000001B,32'd2);
    tbl[11] = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h8000000C,1'b0,32'h8000000C,32'h8000001B,32'd3);
    tbl[12] = mk(1'b1,1'b0,32'd0,1'b1,1'b1,32'h8000001F,1'b1, 1'b1, 1'b0,32'h8000000C,1'b0,32'h8000000C,32'h8000001B,32'd3);
    for (int i = 13; i < 18; i++)
      tbl[i] = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b0, 1'b1, 1'b0,32'h8000000C,1'b1,32'h8000000C,32'h8000001F,32'd3);
    tbl[18] = mk(1'b1,1'b0,32'd0,1'b1,1'b0,32'd0,1'b1, 1'b1, 1'b0,32'h8000000C,1'b1,32'h8000000C,32'h8000001F,32'd3);
    tbl[19] = mk(1'b1,1'b0,32'd0,1'b0,1'b0,32'd0,1'b1, 1'b1, 1'b1,32'h80000010,1'b0,32'h80000010,32'h8000001F,32'd4);

    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();

    for (int i = 0; i < NV; i++) begin
      set_in(tbl[i].rst_v, tbl[i].rv, tbl[i].rpc, tbl[i].rdy, tbl[i].rsv, tbl[i].rsd, tbl[i].ordy);
      if (tbl[i].do_chk)
        chk_out($sformatf("vec%0d", i), tbl[i].e_rqv, tbl[i].e_addr, tbl[i].e_ov,
                tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_cnt);
      tick();
    end

    // Kill in flight: redirect one cycle after 0x80000004 is accepted,
    // response three cycles after acceptance must be dropped.
    reset_dut();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000013, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("kill.first_valid", 32'(out_valid), 32'd1);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("kill.req_addr_seq", imem_req_addr, 32'h80000004);  tick();
    set_in(1'b1, 1'b1, 32'h80000100, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("kill.redir_ov", 32'(out_valid), 32'd0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("kill.wait_rqv", 32'(imem_req_valid), 32'd0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000017, 1'b1);
    chk("kill.resp_ov", 32'(out_valid), 32'd0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
    chk_out("kill.refetch", 1'b1, 32'h80000100, 1'b0, 32'h80000100, 32'h80000013, 32'd1);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000113, 1'b1);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk_out("kill.deliver", 1'b0, 32'h80000100, 1'b1, 32'h80000100, 32'h80000113, 32'd1);  tick();

    // Redirect in the same cycle as the response.
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_out("coin.req", 1'b1, 32'h80000104, 1'b0, 32'h80000104, 32'h80000113, 32'd2);  tick();
    set_in(1'b1, 1'b1, 32'h80000200, 1'b0, 1'b1, 32'h80000117, 1'b0);
    chk("coin.resp_ov", 32'(out_valid), 32'd0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk_out("coin.refetch", 1'b1, 32'h80000200, 1'b0, 32'h80000200, 32'h80000113, 32'd2);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000213, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk_out("coin.deliver", 1'b0, 32'h80000200, 1'b1, 32'h80000200, 32'h80000213, 32'd2);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("coin.cnt", fetch_cnt, 32'd3);  tick();

    // Stalled request with a redirect in its second cycle.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, (i == 1), 32'h80000040, 1'b0, 1'b0, 32'd0, 1'b0);
      chk($sformatf("stall%0d.rqv", i), 32'(imem_req_valid), 32'd1);
      chk($sformatf("stall%0d.addr", i), imem_req_addr, (i <= 1) ? 32'h80000000 : 32'h80000040);
      tick();
    end
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
    chk("stall.accept_addr", imem_req_addr, 32'h80000040);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h80000053, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_out("stall.deliver", 1'b0, 32'h80000040, 1'b1, 32'h80000040, 32'h80000053, 32'd0);
    // Redirect while holding: out_valid masked, no transfer despite out_ready.
    set_in(1'b1, 1'b1, 32'h80000080, 1'b0, 1'b0, 32'd0, 1'b1);
    chk("hold_redir.ov", 32'(out_valid), 32'd0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_out("hold_redir.req", 1'b1, 32'h80000080, 1'b0, 32'h80000080, 32'h80000053, 32'd0);  tick();

    // Reset while holding the eighth instruction with fetch_cnt == 7.
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      p = 32'h80000000 + 32'(i) * 32'd4;
      set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);  tick();
      set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, p ^ 32'h13, 1'b0);  tick();
      set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);  tick();
    end
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h8000000F, 1'b0);  tick();
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_out("pre_reset", 1'b0, 32'h8000001C, 1'b1, 32'h8000001C, 32'h8000000F, 32'd7);
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);  tick();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk_out("mid_reset", 1'b1, 32'h80000000, 1'b0, 32'h80000000, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100012_ifu_bus.md
Name: ysyx_24100012_ifu_bus

Overview:
Multi-cycle instruction fetch unit with a valid/ready handshake to instruction memory, and a second valid/ready handshake towards the decode stage.
- Owns the PC and issues one fetch request at a time.
- Holds the returned instruction until decode accepts it.
- Applies branch/jump redirects from execute, including killing an in-flight fetch.
- Replaces the single-cycle PC-register fetch path when the core moves to a bus-attached instruction memory.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
DATA_WIDTH, 32, instruction word width
ORIGIN_ADDR, 32'h80000000, PC value after reset
WORD_SIZE, 4, sequential PC increment

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the next rising edge)
redirect_valid  in  1  execute requests PC change (taken branch/jump)
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address (= pc register)
imem_resp_valid  in  1  response data valid (one per accepted request)
imem_resp_data  in  DATA_WIDTH  fetched instruction
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts instruction
out_inst  out  DATA_WIDTH  held instruction
out_pc  out  ADDR_WIDTH  PC of out_inst
out_pc_next  out  ADDR_WIDTH  out_pc + WORD_SIZE (link value for jal/jalr)
fetch_cnt  out  32  count of instructions delivered to decode

Behaviour:
- States:
  - REQ: request pending.
  - WAIT: request accepted, awaiting response.
  - HOLD: instruction held for decode.
- Reset (rst==0 at an edge):
  - state=REQ, pc=ORIGIN_ADDR, kill=0, inst_q=0, fetch_cnt=0.
  - Outputs after reset: imem_req_valid=1, imem_req_addr=ORIGIN_ADDR, out_valid=0, out_inst=0, out_pc=ORIGIN_ADDR.
  - Reset overrides everything in any state; a response arriving for a pre-reset request is not consumed after reset, and the memory side must be reset together with this block.
- Combinational outputs:
  - imem_req_valid = (state==REQ).
  - imem_req_addr = pc.
  - out_valid = (state==HOLD) && !redirect_valid.
  - out_pc = pc; out_pc_next = pc + WORD_SIZE (wraps mod 2^ADDR_WIDTH); out_inst = inst_q.
- REQ state:
  - Request not accepted, redirect: pc<=redirect_pc, stay REQ. The address may change while the request is not yet accepted; the memory samples it only on valid&&ready.
  - Accept (imem_req_ready=1), no redirect: go to WAIT.
  - Accept and redirect in the same cycle: pc<=redirect_pc, kill<=1, go to WAIT.
- WAIT state:
  - Redirect: pc<=redirect_pc, kill<=1.
  - imem_resp_valid with kill==1, or with redirect_valid in the same cycle: discard data, kill<=0, go to REQ.
  - imem_resp_valid otherwise: inst_q<=imem_resp_data, go to HOLD.
  - Responses are accepted unconditionally (no resp_ready).
  - imem_resp_valid in REQ or HOLD is a protocol error and is ignored.
- HOLD state:
  - Redirect (any out_ready): pc<=redirect_pc, go to REQ. No transfer occurs because out_valid is masked.
  - out_ready && !redirect_valid: transfer; pc<=pc+WORD_SIZE, fetch_cnt<=fetch_cnt+1, go to REQ.
  - Otherwise hold with out_inst and out_pc stable.
- Latency and throughput:
  - With ready=1 and a next-cycle response: request at cycle t, response at t+1, out_valid at t+2.
  - Best-case throughput is 1 instruction per 3 cycles.
- Redirect precedence: a redirect always wins over sequential increment, and the last redirect before a new request is issued wins.
- fetch_cnt wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset/sequential: rst=0 for 2 cycles then 1; memory always ready, 1-cycle latency, returns addr^0x13; out_ready=1 → out_pc sequence 0x80000000, 0x80000004, 0x80000008 on cycles 3, 6, 9 after reset release; out_inst matches; fetch_cnt=3.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid stays 1 and out_inst/out_pc are unchanged; no new imem_req_valid; the transfer completes on the first cycle with out_ready=1.
- Kill in flight: redirect_valid=1 with redirect_pc=0x80000100 one cycle after an accepted request to 0x80000004, response 3 cycles later → that data is never presented; next imem_req_addr=0x80000100.
- Redirect coincident with response: redirect_pc=0x80000200 in the same cycle as imem_resp_valid → response discarded; next request to 0x80000200, which is delivered with out_pc=0x80000200.
- Stall in REQ plus redirect: imem_req_ready=0 for 4 cycles, redirect to 0x80000040 at cycle 2 → the first accepted address is 0x80000040, and 0x80000000 is never accepted.
- Reset mid-operation: assert rst=0 while in HOLD with fetch_cnt=7 → the next cycle shows out_valid=0, imem_req_addr=0x80000000, fetch_cnt=0.
